// File: rtl/disp_rd_master.sv
// rtl/disp_rd_master.sv - AXI4 read master streaming one display frame into the pixel FIFO
module disp_rd_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_BYTES  = 8,
    parameter int BURST_BEATS = 16,
    parameter int MAX_OUTST   = 4,
    parameter int FSIZE_W     = 24,
    parameter int LVL_W       = 10
) (
    input  logic               ACLK,
    input  logic               ARST,
    output logic [ADDR_W-1:0]  ARADDR,
    output logic [7:0]         ARLEN,
    output logic               ARVALID,
    input  logic               ARREADY,
    input  logic               RVALID,
    input  logic               RLAST,
    input  logic [1:0]         RRESP,
    output logic               RREADY,
    input  logic               AXISTART,
    input  logic               DISPON,
    input  logic [ADDR_W-1:0]  DISPADDR,
    input  logic [FSIZE_W-1:0] FRAMEBYTES,
    input  logic [LVL_W-1:0]   FIFOFREE,
    output logic               BUSY,
    output logic               FRAMEDONE,
    output logic               RERR
);
    localparam int BURST_BYTES = BURST_BEATS * DATA_BYTES;
    localparam int OFF_W       = FSIZE_W + 1;
    localparam int OUT_W       = $clog2(MAX_OUTST + 1);
    localparam int PEND_W      = $clog2(MAX_OUTST * BURST_BEATS + 1);
    localparam int CMP_W       = ((LVL_W > PEND_W) ? LVL_W : PEND_W) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [2:0]         start_ff;
    logic [ADDR_W-1:0]  base;
    logic [FSIZE_W-1:0] fsize;
    logic [OFF_W-1:0]   offset;
    logic [OUT_W-1:0]   outst;
    logic [PEND_W-1:0]  pend;
    logic               aborted;

    logic dispstart;
    logic ar_hs;
    logic r_last;
    logic more;
    logic credit_ok;

    assign dispstart = DISPON & (start_ff[2:1] == 2'b01);
    assign ar_hs     = ARVALID & ARREADY;
    assign r_last    = RVALID & RLAST;
    assign more      = offset < {1'b0, fsize};
    // A burst may only be requested once its beats are guaranteed to fit in the FIFO
    assign credit_ok = (CMP_W'(FIFOFREE) >= CMP_W'(pend) + CMP_W'(BURST_BEATS))
                       && (outst < OUT_W'(MAX_OUTST));
    assign ARLEN     = 8'(BURST_BEATS - 1);
    assign RREADY    = RVALID;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state     <= IDLE;
            start_ff  <= 3'b000;
            base      <= '0;
            fsize     <= '0;
            offset    <= '0;
            outst     <= '0;
            pend      <= '0;
            aborted   <= 1'b0;
            ARVALID   <= 1'b0;
            ARADDR    <= '0;
            BUSY      <= 1'b0;
            FRAMEDONE <= 1'b0;
            RERR      <= 1'b0;
        end else begin
            start_ff  <= {start_ff[1:0], AXISTART};
            FRAMEDONE <= 1'b0;

            case ({ar_hs, r_last})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   if (outst != '0) outst <= outst - 1'b1;
                default: ;
            endcase

            if (ar_hs && RVALID)
                pend <= pend + PEND_W'(BURST_BEATS - 1);
            else if (ar_hs)
                pend <= pend + PEND_W'(BURST_BEATS);
            else if (RVALID && pend != '0)
                pend <= pend - 1'b1;

            if (RVALID && RRESP != 2'b00)
                RERR <= 1'b1;

            if (ar_hs) begin
                ARVALID <= 1'b0;
                offset  <= offset + OFF_W'(BURST_BYTES);
            end

            case (state)
                IDLE: begin
                    if (dispstart) begin
                        state   <= ISSUE;
                        BUSY    <= 1'b1;
                        base    <= DISPADDR;
                        fsize   <= FRAMEBYTES;
                        offset  <= '0;
                        RERR    <= 1'b0;
                        aborted <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (!DISPON)
                        aborted <= 1'b1;
                    // A pending request is never retracted, so decisions wait for ARVALID low
                    if (!ARVALID) begin
                        if (!more || !DISPON) begin
                            state <= DRAIN;
                        end else if (credit_ok) begin
                            ARVALID <= 1'b1;
                            ARADDR  <= base + ADDR_W'(offset);
                        end
                    end
                end
                DRAIN: begin
                    if (!DISPON)
                        aborted <= 1'b1;
                    if (outst == '0) begin
                        if (aborted || !DISPON) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state     <= DONE;
                            FRAMEDONE <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/disp_rd_master.md
Name: disp_rd_master

Overview:
- Parametrised AXI4 read master that streams one display frame from memory into the downstream pixel FIFO.
- Next generation of the single-burst display fetcher: frame base, frame size and burst size are programmable, up to MAX_OUTST bursts may be in flight, and FIFO credit is checked against a free-space level rather than a single ready bit.
- Sits between the VRAM AXI port and the display FIFO. Triggered by the display timing start strobe.

Parameters:
ADDR_W, 32, AXI address width
DATA_BYTES, 8, bytes per R beat (bus width / 8), power of 2
BURST_BEATS, 16, beats per burst (1..256), power of 2
MAX_OUTST, 4, maximum AR handshakes without a matching RLAST (1..15)
FSIZE_W, 24, width of frame-size input in bytes
LVL_W, 10, width of FIFO free-level input in beats

Ports:
ACLK  in  1  clock
ARST  in  1  reset
ARADDR  out  ADDR_W  burst start address
ARLEN  out  8  constant BURST_BEATS-1
ARVALID  out  1  address valid
ARREADY  in  1  address ready
RVALID  in  1  read data valid
RLAST  in  1  last beat of burst
RRESP  in  2  read response
RREADY  out  1  read data ready
AXISTART  in  1  frame start strobe, asynchronous to ACLK
DISPON  in  1  display enable
DISPADDR  in  ADDR_W  frame base address, burst-aligned
FRAMEBYTES  in  FSIZE_W  frame size in bytes
FIFOFREE  in  LVL_W  free beats in downstream FIFO
BUSY  out  1  frame fetch in progress
FRAMEDONE  out  1  one-cycle pulse when a frame completes
RERR  out  1  sticky error: non-OKAY RRESP seen this frame

Behaviour:
- Reset: ARST is synchronous, active-high; clock is ACLK. On reset:
  - ARVALID, BUSY, FRAMEDONE and RERR are 0.
  - ARADDR is 0.
  - All counters and the synchroniser are cleared.
  - State goes to IDLE.
  - Reset mid-frame abandons outstanding bursts with no drain.
- Start detection: AXISTART passes through a 3-flop synchroniser. dispstart = DISPON & (ff[2:1]==2'b01).
- State machine, 2-bit: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on dispstart.
    - Latch base = DISPADDR and fsize = FRAMEBYTES.
    - Clear offset and RERR.
    - dispstart in any other state is ignored.
  - ISSUE -> DRAIN when offset >= fsize, or when DISPON==0. Either condition is evaluated only while ARVALID==0.
  - DRAIN -> DONE when outst==0 and DISPON was high throughout the frame.
  - DRAIN -> IDLE when outst==0 and the frame was aborted.
  - DONE -> IDLE unconditionally. FRAMEDONE=1 only in the DONE cycle.
- BUSY=1 in any state except IDLE.
- AR channel:
  - ARVALID is registered.
  - It is set in ISSUE when all of the following hold: ARVALID==0, offset<fsize, DISPON, outst<MAX_OUTST, and FIFOFREE >= pend + BURST_BEATS.
  - ARADDR = base + zero-extended offset, modulo 2^ADDR_W. It is registered with ARVALID.
  - ARVALID and ARADDR stay stable until ARREADY. There is no retraction, even if DISPON falls.
  - On handshake: offset += BURST_BEATS*DATA_BYTES, and ARVALID clears. Minimum one idle cycle between requests.
  - A frame size that is not a burst multiple is rounded up: the last burst is full. FRAMEBYTES=0 means no bursts are issued and the path is IDLE -> ISSUE -> DRAIN -> DONE.
- R channel:
  - RREADY = RVALID. FIFO space is guaranteed by the reservation check.
  - Any beat with RRESP != 0 sets RERR. RERR holds until the next frame start or reset.
- Counters:
  - outst: +1 on AR handshake, -1 on RVALID&RLAST. Both in the same cycle leaves it unchanged. Width is clog2(MAX_OUTST+1).
  - pend (reserved beats): +BURST_BEATS on AR handshake, -1 per RVALID beat. Both in the same cycle gives a net of +BURST_BEATS-1.
  - An RLAST arriving while outst==0 is a protocol violation. outst saturates at 0 (no wrap) and pend saturates at 0.
- Latency: ARVALID rises 2 cycles after the synchronised edge is detected, i.e. 1 cycle in IDLE->ISSUE plus 1 cycle for the register, provided the credit check passes.

Test Plan:
- Reset, then FRAMEBYTES=1024, DATA_BYTES=8, BURST_BEATS=16, DISPADDR=0x1000_0000, FIFOFREE=512, ARREADY=1, memory model at zero latency -> exactly 8 ARs with ARADDR 0x1000_0000..0x1000_0380 step 0x80, ARLEN=15. FRAMEDONE pulses once after the 8th RLAST, BUSY falls on the next cycle.
- Memory with 20-cycle read latency, MAX_OUTST=4 -> outst peaks at 4, and no 5th ARVALID appears before the first RLAST.
- FIFOFREE held at 40 with BURST_BEATS=16 -> at most 2 bursts are reserved. A third ARVALID appears only after pend drops to 24 or below.
- ARREADY held low for 10 cycles while DISPON is dropped mid-stall -> ARVALID and ARADDR remain stable until ARREADY, no further AR is issued, outstanding bursts drain, the state returns to IDLE, and FRAMEDONE stays 0.
- FRAMEBYTES=0 -> no ARVALID, and FRAMEDONE pulses 3 cycles after dispstart. FRAMEBYTES=200 -> 2 bursts issued (rounded up).
- RRESP=2'b10 on one beat -> RERR=1 and holds through FRAMEDONE. A second AXISTART edge during BUSY is ignored. The next frame start clears RERR.
